// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: AHB-Lite register bank with byte/half/word writes, wait states,
// read-only hardware status slots and a two-cycle ERROR response.
module ahb_reg_slave #(
  parameter int                      NUM_REGS    = 16,
  parameter int                      WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]     RO_MASK     = '0,
  parameter logic [NUM_REGS*32-1:0]  RESET_VAL   = '0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HSEL,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [3:0]               HPROT,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HREADYOUT,
  output logic [1:0]               HRESP,
  output logic [NUM_REGS*32-1:0]   reg_q,
  input  logic [NUM_REGS*32-1:0]   reg_hw_d,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int NP = 1 << AW;
  localparam logic [NP-1:0] RO_EXT = NP'(RO_MASK);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t              state_q, state_d;
  logic                act_q, act_d, wr_q, wr_d;
  logic [AW-1:0]       idx_q, idx_d, a_idx;
  logic [3:0]          mask_q, mask_d, a_mask;
  logic [2:0]          cnt_q, cnt_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic                rdy, acc, err, commit, unused_ok;
  assign unused_ok = ^{HTRANS[0], HBURST, HPROT, HADDR[31:AW+2]};
  assign a_idx     = HADDR[AW+1:2];
  assign a_mask    = HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] :
                     HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign err       = ({1'b0, a_idx} >= (AW+1)'(NUM_REGS)) | (HSIZE > 3'b010) |
                     (HSIZE == 3'b001 & HADDR[0]) | (HSIZE == 3'b010 & |HADDR[1:0]) |
                     (HWRITE & RO_EXT[a_idx]);
  // ready is low while counting wait states and in the first error cycle
  assign rdy       = state_q == S_WAIT ? cnt_q == 3'(WAIT_STATES) : state_q != S_ERR1;
  assign acc       = HSEL & HTRANS[1] & HREADY & rdy;
  assign commit    = act_q & wr_q & rdy;
  assign HREADYOUT = rdy;
  assign HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
  assign HRDATA    = act_q & ~wr_q ? (RO_EXT[idx_q] ? reg_hw_d[{idx_q, 5'b0} +: 32] : regs_q[idx_q]) : 32'h0;
  assign reg_wr_pulse = pulse_q;
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    if (state_q == S_ERR1) state_d = S_ERR2;
    else if (state_q == S_WAIT && !rdy) cnt_d = cnt_q + 3'd1;
    else begin
      act_d   = acc & ~err;
      wr_d    = HWRITE;
      idx_d   = a_idx;
      mask_d  = a_mask;
      cnt_d   = '0;
      state_d = !acc ? S_IDLE : err ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_IDLE;
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pulse_d[i] = commit && idx_q == AW'(i);
      regs_d[i]  = regs_q[i];
      for (int b = 0; b < 4; b++)
        if (pulse_d[i] && mask_q[b] && !RO_MASK[i]) regs_d[i][8*b +: 8] = HWDATA[8*b +: 8];
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      act_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_q[32*g +: 32] = RO_MASK[g] ? 32'h0 : regs_q[g];
  end
endmodule
